fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, single instruction register.
// Redirects during an in-flight request drain the stale response before refetching.
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [3:0]  cond,
  output logic [1:0]  op,
  output logic [5:0]  funct,
  output logic [3:0]  rd,
  output logic [31:0] pc_plus8,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DISCARD,
    HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] redir;

  assign redir = branch_target & ~32'h3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      pend_q  <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (pc_src && imem_ready) begin
          pc_d = redir;
        end else if (pc_src) begin
          pend_d  = redir;
          state_d = DISCARD;
        end else if (imem_ready) begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          pc_d    = pc_q + 32'd4;
          cnt_d   = cnt_q + 16'd1;
          state_d = HOLD;
        end
      end
      // pc keeps the stale address on the bus; pend_q holds the target
      DISCARD: begin
        if (imem_ready) begin
          pc_d    = pc_src ? redir : pend_q;
          state_d = FETCH;
        end else if (pc_src) begin
          pend_d = redir;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          if (pc_src) pc_d = redir;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req    = (state_q == FETCH) || (state_q == DISCARD);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign cond        = instr_q[31:28];
  assign op          = instr_q[27:26];
  assign funct       = instr_q[25:20];
  assign rd          = instr_q[15:12];
  assign pc_plus8    = ipc_q + 32'd8;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit.
// Inputs change and outputs are sampled on the falling edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;
  logic [31:0] pc_plus8;
  logic        pc_src;
  logic [31:0] branch_target;
  logic [15:0] fetch_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .cond          (cond),
    .op            (op),
    .funct         (funct),
    .rd            (rd),
    .pc_plus8      (pc_plus8),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .fetch_count   (fetch_count)
  );

  task automatic deliver(input logic [31:0] d);
    imem_ready = 1'b1;
    imem_rdata = d;
    @(negedge clk);
    imem_ready = 1'b0;
  endtask

  task automatic consume(input logic br, input logic [31:0] tgt);
    instr_ready   = 1'b1;
    pc_src        = br;
    branch_target = tgt;
    @(negedge clk);
    instr_ready = 1'b0;
    pc_src      = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b0)
      $display("FAIL rst_req: got %b exp 0", imem_req);
    else passed++;
    total++;
    if (instr_valid !== 1'b0)
      $display("FAIL rst_valid: got %b exp 0", instr_valid);
    else passed++;
    total++;
    if (instr !== 32'h0)
      $display("FAIL rst_instr: got %h exp 0", instr);
    else passed++;
    total++;
    if (fetch_count !== 16'h0)
      $display("FAIL rst_count: got %h exp 0", fetch_count);
    else passed++;
    total++;
    if (imem_addr !== 32'h0 || pc_plus8 !== 32'h8)
      $display("FAIL rst_pc: got addr %h pc8 %h exp 0/8",
               imem_addr, pc_plus8);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_first_fetch;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL ff_req: got %b/%h exp 1/0", imem_req, imem_addr);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0)
      $display("FAIL ff_wait: got %b/%h/%b exp 1/0/0",
               imem_req, imem_addr, instr_valid);
    else passed++;
    deliver(32'hE3A01005);
    total++;
    if (instr_valid !== 1'b1 || instr !== 32'hE3A01005)
      $display("FAIL ff_instr: got %b/%h exp 1/e3a01005", instr_valid, instr);
    else passed++;
    total++;
    if (cond !== 4'b1110 || op !== 2'b00 ||
        funct !== 6'b111010 || rd !== 4'b0001)
      $display("FAIL ff_fields: got %b %b %b %b exp 1110 00 111010 0001",
               cond, op, funct, rd);
    else passed++;
    total++;
    if (pc_plus8 !== 32'h8 || fetch_count !== 16'd1 || imem_req !== 1'b0)
      $display("FAIL ff_pc8cnt: got %h/%0d/%b exp 8/1/0",
               pc_plus8, fetch_count, imem_req);
    else passed++;
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 ||
          instr !== 32'hE3A01005)
        $display("FAIL bp_hold%0d: got %b/%b/%h exp 1/0/e3a01005",
                 i, instr_valid, imem_req, instr);
      else passed++;
    end
    consume(1'b0, 32'h0);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0)
      $display("FAIL bp_next: got %b/%h/%b exp 1/4/0",
               imem_req, imem_addr, instr_valid);
    else passed++;
    deliver(32'hE0811002);
    total++;
    if (pc_plus8 !== 32'hC || fetch_count !== 16'd2 || rd !== 4'd1)
      $display("FAIL bp_second: got %h/%0d/%h exp c/2/1",
               pc_plus8, fetch_count, rd);
    else passed++;
  endtask

  task automatic test_branch_consume;
    consume(1'b1, 32'h0000_0103);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100)
      $display("FAIL br_addr: got %b/%h exp 1/100", imem_req, imem_addr);
    else passed++;
    deliver(32'hE2833001);
    total++;
    if (pc_plus8 !== 32'h108 || fetch_count !== 16'd3)
      $display("FAIL br_pc8: got %h/%0d exp 108/3", pc_plus8, fetch_count);
    else passed++;
  endtask

  task automatic test_redirect_inflight;
    consume(1'b1, 32'h8);
    total++;
    if (imem_addr !== 32'h8)
      $display("FAIL rif_start: got %h exp 8", imem_addr);
    else passed++;
    pc_src        = 1'b1;
    branch_target = 32'h40;
    @(negedge clk);
    pc_src = 1'b0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0)
      $display("FAIL rif_held: got %b/%h/%b exp 1/8/0",
               imem_req, imem_addr, instr_valid);
    else passed++;
    @(negedge clk);
    deliver(32'hDEADBEEF);
    total++;
    if (instr_valid !== 1'b0 || instr !== 32'hE2833001)
      $display("FAIL rif_drop: got %b/%h exp 0/e2833001", instr_valid, instr);
    else passed++;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40 || fetch_count !== 16'd3)
      $display("FAIL rif_next: got %b/%h/%0d exp 1/40/3",
               imem_req, imem_addr, fetch_count);
    else passed++;
  endtask

  task automatic test_discard_retarget;
    pc_src        = 1'b1;
    branch_target = 32'h80;
    @(negedge clk);
    branch_target = 32'h202;
    @(negedge clk);
    pc_src = 1'b0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40)
      $display("FAIL dr_held: got %b/%h exp 1/40", imem_req, imem_addr);
    else passed++;
    deliver(32'hAAAA0000);
    total++;
    if (imem_addr !== 32'h200 || instr_valid !== 1'b0 ||
        instr !== 32'hE2833001)
      $display("FAIL dr_target: got %h/%b/%h exp 200/0/e2833001",
               imem_addr, instr_valid, instr);
    else passed++;
  endtask

  task automatic test_same_cycle;
    pc_src        = 1'b1;
    branch_target = 32'h300;
    imem_ready    = 1'b1;
    imem_rdata    = 32'h12345678;
    @(negedge clk);
    pc_src     = 1'b0;
    imem_ready = 1'b0;
    total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300)
      $display("FAIL sc_redir: got %b/%b/%h exp 0/1/300",
               instr_valid, imem_req, imem_addr);
    else passed++;
    total++;
    if (instr !== 32'hE2833001 || fetch_count !== 16'd3)
      $display("FAIL sc_drop: got %h/%0d exp e2833001/3", instr, fetch_count);
    else passed++;
    deliver(32'hE1A0F00E);
    total++;
    if (pc_plus8 !== 32'h308 || fetch_count !== 16'd4 || rd !== 4'hF)
      $display("FAIL sc_fetch: got %h/%0d/%h exp 308/4/f",
               pc_plus8, fetch_count, rd);
    else passed++;
  endtask

  task automatic test_hold_ignore;
    pc_src        = 1'b1;
    branch_target = 32'h500;
    @(negedge clk);
    pc_src = 1'b0;
    total++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== 32'hE1A0F00E)
      $display("FAIL hi_stable: got %b/%b/%h exp 1/0/e1a0f00e",
               instr_valid, imem_req, instr);
    else passed++;
    consume(1'b0, 32'h0);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h304)
      $display("FAIL hi_next: got %b/%h exp 1/304", imem_req, imem_addr);
    else passed++;
  endtask

  task automatic test_wrap_pc;
    deliver(32'h01234567);
    consume(1'b1, 32'hFFFF_FFFF);
    total++;
    if (imem_addr !== 32'hFFFF_FFFC)
      $display("FAIL wp_addr: got %h exp fffffffc", imem_addr);
    else passed++;
    deliver(32'hF0000000);
    total++;
    if (pc_plus8 !== 32'h4 || cond !== 4'hF || fetch_count !== 16'd6)
      $display("FAIL wp_pc8: got %h/%h/%0d exp 4/f/6",
               pc_plus8, cond, fetch_count);
    else passed++;
    consume(1'b0, 32'h0);
    total++;
    if (imem_addr !== 32'h0 || imem_req !== 1'b1)
      $display("FAIL wp_next: got %h/%b exp 0/1", imem_addr, imem_req);
    else passed++;
  endtask

  task automatic test_reset_midreq;
    deliver(32'h0);
    consume(1'b1, 32'h10);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10)
      $display("FAIL rm_pre: got %b/%h exp 1/10", imem_req, imem_addr);
    else passed++;
    #2;
    reset      = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hBADBAD00;
    #1;
    total++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0)
      $display("FAIL rm_async: got %b/%b/%h exp 0/0/0",
               imem_req, instr_valid, imem_addr);
    else passed++;
    total++;
    if (fetch_count !== 16'h0 || instr !== 32'h0)
      $display("FAIL rm_clear: got %h/%h exp 0/0", fetch_count, instr);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    imem_ready = 1'b0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 ||
        instr_valid !== 1'b0 || fetch_count !== 16'h0)
      $display("FAIL rm_first: got %b/%h/%b/%0d exp 1/0/0/0",
               imem_req, imem_addr, instr_valid, fetch_count);
    else passed++;
  endtask

  task automatic test_count_wrap;
    imem_ready  = 1'b1;
    instr_ready = 1'b1;
    imem_rdata  = 32'hE3A00000;
    for (int i = 0; i < 140000 && fetch_count !== 16'hFFFF; i++)
      @(negedge clk);
    total++;
    if (fetch_count !== 16'hFFFF || instr_valid !== 1'b1)
      $display("FAIL cw_preset: got %h/%b exp ffff/1",
               fetch_count, instr_valid);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    imem_ready  = 1'b0;
    instr_ready = 1'b0;
    total++;
    if (fetch_count !== 16'h0000 || instr_valid !== 1'b1)
      $display("FAIL cw_wrap: got %h/%b exp 0000/1",
               fetch_count, instr_valid);
    else passed++;
  endtask

  initial begin
    reset         = 1'b1;
    imem_ready    = 1'b0;
    imem_rdata    = 32'h0;
    instr_ready   = 1'b0;
    pc_src        = 1'b0;
    branch_target = 32'h0;
    @(negedge clk);
    test_reset;
    test_first_fetch;
    test_backpressure;
    test_branch_consume;
    test_redirect_inflight;
    test_discard_retarget;
    test_same_cycle;
    test_hold_ignore;
    test_wrap_pc;
    test_reset_midreq;
    test_count_wrap;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
